// File: rtl/ldpc_iter_sched.sv
// Iteration scheduler for the layered LDPC parity-check stage: drives column
// read/write address streams and iteration control until parity passes or the budget runs out.
module ldpc_iter_sched #(
    parameter int PCM_COLN    = 127,
    parameter int COL_CNT_WID = 7,
    parameter int RW_LATENCY  = 2,
    parameter int ITER_WID    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [ITER_WID-1:0]    i_max_iter,
    input  logic                   i_parity_check_ok,
    input  logic                   i_decoded_info_last,
    output logic                   o_busy,
    output logic                   o_decoding,
    output logic                   o_is_first_iter,
    output logic                   o_decode_end,
    output logic [COL_CNT_WID-1:0] o_col_cnt_mem,
    output logic [COL_CNT_WID-1:0] o_col_cnt,
    output logic [ITER_WID-1:0]    o_iter_cnt,
    output logic                   o_done,
    output logic                   o_success
);

    localparam int PW = $clog2(RW_LATENCY + 1);
    localparam logic [COL_CNT_WID-1:0] LAST_COL = COL_CNT_WID'(PCM_COLN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nx;

    logic [COL_CNT_WID-1:0] col_cnt_mem;
    logic [COL_CNT_WID-1:0] dl [RW_LATENCY];
    logic [RW_LATENCY-1:0]  dl_vld;
    logic [PW-1:0]          prime_cnt;
    logic [ITER_WID-1:0]    iter_cnt;
    logic [ITER_WID-1:0]    r_max;
    logic                   r_chk;
    logic                   r_ok;

    logic                   stop;
    logic                   advance;
    logic                   wr_wrap;
    logic                   accept;

    assign wr_wrap = dl_vld[RW_LATENCY-1] && (dl[RW_LATENCY-1] == LAST_COL);
    assign accept  = (state == IDLE) && i_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        stop            = 1'b0;
        advance         = 1'b0;
        o_busy          = 1'b0;
        o_decoding      = 1'b0;
        o_is_first_iter = 1'b0;
        o_done          = 1'b0;
        o_success       = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = PRIME;
                end
            end
            PRIME: begin
                o_busy  = 1'b1;
                advance = 1'b1;
                if (prime_cnt == PW'(RW_LATENCY - 1)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                o_busy          = 1'b1;
                o_decoding      = 1'b1;
                o_is_first_iter = (iter_cnt == '0);
                // r_chk marks the first cycle carrying the freshly incremented iteration count
                if (r_chk && (i_parity_check_ok || (iter_cnt == r_max))) begin
                    stop     = 1'b1;
                    state_nx = DRAIN;
                end else begin
                    advance = 1'b1;
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (i_decoded_info_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                o_success = r_ok;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_mem <= '0;
            dl_vld      <= '0;
            prime_cnt   <= '0;
            iter_cnt    <= '0;
            r_max       <= '0;
            r_chk       <= 1'b0;
            for (int unsigned i = 0; i < RW_LATENCY; i++) begin
                dl[i] <= '0;
            end
        end else if (accept) begin
            col_cnt_mem <= '0;
            dl_vld      <= '0;
            prime_cnt   <= '0;
            iter_cnt    <= '0;
            r_chk       <= 1'b0;
            r_max       <= (i_max_iter == '0) ? ITER_WID'(1) : i_max_iter;
            for (int unsigned i = 0; i < RW_LATENCY; i++) begin
                dl[i] <= '0;
            end
        end else if (advance) begin
            col_cnt_mem <= (col_cnt_mem == LAST_COL) ? '0 : col_cnt_mem + COL_CNT_WID'(1);
            dl[0]       <= col_cnt_mem;
            dl_vld[0]   <= 1'b1;
            for (int unsigned i = 1; i < RW_LATENCY; i++) begin
                dl[i]     <= dl[i-1];
                dl_vld[i] <= dl_vld[i-1];
            end
            if (state == PRIME) begin
                prime_cnt <= prime_cnt + PW'(1);
            end
            if ((state == RUN) && wr_wrap) begin
                iter_cnt <= iter_cnt + ITER_WID'(1);
            end
            r_chk <= (state == RUN) && wr_wrap;
        end else begin
            r_chk <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ok <= 1'b0;
        end else if (stop) begin
            r_ok <= i_parity_check_ok;
        end
    end

    assign o_decode_end  = stop;
    assign o_col_cnt_mem = col_cnt_mem;
    assign o_col_cnt     = dl[RW_LATENCY-1];
    assign o_iter_cnt    = iter_cnt;

endmodule

// File: tb/tb_ldpc_iter_sched.sv
// Randomized self-checking bench for ldpc_iter_sched against a cycle-index reference model.
module tb_ldpc_iter_sched;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int CW = 3;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [IW-1:0] max_iter = '0;
    logic          ok = 1'b0;
    logic          last = 1'b0;

    logic          o_busy, o_decoding, o_is_first_iter, o_decode_end, o_done, o_success;
    logic [CW-1:0] o_col_cnt_mem, o_col_cnt;
    logic [IW-1:0] o_iter_cnt;

    ldpc_iter_sched #(
        .PCM_COLN   (N),
        .COL_CNT_WID(CW),
        .RW_LATENCY (L),
        .ITER_WID   (IW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (i_start),
        .i_max_iter         (max_iter),
        .i_parity_check_ok  (ok),
        .i_decoded_info_last(last),
        .o_busy             (o_busy),
        .o_decoding         (o_decoding),
        .o_is_first_iter    (o_is_first_iter),
        .o_decode_end       (o_decode_end),
        .o_col_cnt_mem      (o_col_cnt_mem),
        .o_col_cnt          (o_col_cnt),
        .o_iter_cnt         (o_iter_cnt),
        .o_done             (o_done),
        .o_success          (o_success)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position inside a run is the cycle index since start acceptance.
    bit m_busy = 0, m_end = 0, m_done = 0, m_ok = 0;
    int m_n = 0, m_max = 1;
    int m_fmem = 0, m_fcol = 0, m_fiter = 0;

    int cyc = 0, c_drive = 0;
    int n_end = 0, n_first = 0, dec_end_n = 0;
    bit saw_done = 0;
    logic [31:0] d_iter = '0, d_succ = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int j, e_busy, e_dec, e_first, e_end, e_mem, e_col, e_iter, e_done, e_succ;
        j = 0; e_busy = 0; e_dec = 0; e_first = 0; e_end = 0; e_done = 0; e_succ = 0;
        e_mem = m_fmem; e_col = m_fcol; e_iter = m_fiter;
        if (!rst_n) begin
            m_busy = 0; m_end = 0; m_done = 0; m_ok = 0;
            m_fmem = 0; m_fcol = 0; m_fiter = 0;
            e_mem = 0; e_col = 0; e_iter = 0;
        end else if (m_done) begin
            e_done = 1;
            e_succ = m_ok ? 1 : 0;
        end else if (m_busy) begin
            e_busy = 1;
            if (!m_end) begin
                if (m_n <= L) begin
                    e_mem = m_n - 1; e_col = 0; e_iter = 0;
                end else begin
                    j       = m_n - L - 1;
                    e_mem   = (j + L) % N;
                    e_col   = j % N;
                    e_iter  = j / N;
                    e_first = (e_iter == 0) ? 1 : 0;
                    e_dec   = 1;
                    e_end   = (j > 0 && j % N == 0 && (ok == 1'b1 || e_iter == m_max)) ? 1 : 0;
                end
            end
        end
        check("busy",       32'(o_busy),          e_busy);
        check("decoding",   32'(o_decoding),      e_dec);
        check("first_iter", 32'(o_is_first_iter), e_first);
        check("decode_end", 32'(o_decode_end),    e_end);
        check("col_mem",    32'(o_col_cnt_mem),   e_mem);
        check("col_wr",     32'(o_col_cnt),       e_col);
        check("iter_cnt",   32'(o_iter_cnt),      e_iter);
        check("done",       32'(o_done),          e_done);
        check("success",    32'(o_success),       e_succ);

        if (o_decode_end === 1'b1) begin n_end++; dec_end_n = cyc - c_drive; end
        if (o_is_first_iter === 1'b1) n_first++;
        if (o_done === 1'b1) begin saw_done = 1; d_iter = 32'(o_iter_cnt); d_succ = 32'(o_success); end

        if (rst_n) begin
            if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if (i_start) begin
                    m_busy = 1; m_n = 1; m_end = 0;
                    m_max  = (max_iter == '0) ? 1 : int'(max_iter);
                end
            end else if (m_end) begin
                if (last) begin m_done = 1; m_busy = 0; end
            end else if (e_end == 1) begin
                m_end = 1; m_ok = ok;
                m_fmem = e_mem; m_fcol = e_col; m_fiter = e_iter;
            end else begin
                m_n++;
            end
        end
    end

    function automatic int run_j();
        if (m_busy && !m_end && m_n > L) return m_n - L - 1;
        return -1;
    endfunction

    // mode 0: OK never; 1: OK at check point after iteration k; 2: OK pulse at column 1; 3: random OK
    task automatic run_test(input int mx, input int mode, input int k);
        int guard, j;
        @(posedge clk); #1;
        max_iter = IW'(mx); i_start = 1'b1; c_drive = cyc;
        n_end = 0; n_first = 0; saw_done = 0;
        @(posedge clk); #1;
        i_start  = 1'b0;
        max_iter = IW'($urandom_range(31));
        guard = 0;
        while (!saw_done && guard < 2000) begin
            j       = run_j();
            i_start = m_busy && ($urandom_range(4) == 0);
            case (mode)
                1:       ok = (j > 0 && j % N == 0 && j / N == k);
                2:       ok = (j >= 0 && j % N == 1);
                3:       ok = ($urandom_range(5) == 0);
                default: ok = 1'b0;
            endcase
            last = m_end && ($urandom_range(2) == 0);
            @(posedge clk); #1;
            guard++;
        end
        i_start = 1'b0; ok = 1'b0; last = 1'b0;
        if (!saw_done) check("done_timeout", 0, 1);
    endtask

    task automatic reset_during_run();
        int guard, j;
        @(posedge clk); #1;
        max_iter = IW'(5); i_start = 1'b1; c_drive = cyc; saw_done = 0;
        @(posedge clk); #1;
        i_start = 1'b0;
        guard = 0;
        j = run_j();
        while (!(j >= N && j % N == 2) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
            j = run_j();
        end
        if (guard >= 500) check("reset_wait_timeout", 0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(o_busy),        0);
        check("rst_dec",    32'(o_decoding),    0);
        check("rst_colmem", 32'(o_col_cnt_mem), 0);
        check("rst_col",    32'(o_col_cnt),     0);
        check("rst_iter",   32'(o_iter_cnt),    0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_done", 32'(saw_done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_test(3, 0, 0);
        check("budget_end_cycle", dec_end_n, 15);
        check("budget_end_count", n_end, 1);
        check("budget_iter", d_iter, 3);
        check("budget_succ", d_succ, 0);

        run_test(3, 1, 2);
        check("early_end_count", n_end, 1);
        check("early_iter", d_iter, 2);
        check("early_succ", d_succ, 1);

        run_test(3, 2, 0);
        check("midok_iter", d_iter, 3);
        check("midok_succ", d_succ, 0);

        run_test(0, 0, 0);
        check("zero_first_cycles", n_first, 4);
        check("zero_iter", d_iter, 1);

        repeat (12) run_test($urandom_range(6), 3, 0);

        reset_during_run();

        run_test(2, 0, 0);
        check("restart_iter", d_iter, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
